// File: rtl/pipemem_stage.sv
// ---------------------------------------------------------------------------
// pipemem_stage
//   Memory stage of the 5-stage pipelined CPU. Holds the EX/MEM pipeline
//   register, drives a req/ack data-memory port for byte/half/word loads and
//   stores, extends load data, and stalls upstream stages while an access is
//   outstanding. A misaligned access is suppressed. An access that gets no
//   acknowledge within TIMEOUT cycles is aborted and retires as a bubble.
//
// Ports
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   ealu, eb, ern        EX result/address, store data, destination register
//   ewreg, em2reg, ewmem EX register-write, load and store flags
//   esize, esext         access size (00 b, 01 h, 1x w) and sign-extend select
//   dack, drdata         memory acknowledge and load data
//   malu, mmo, mrn       registered result, extended load data, destination
//   mwreg, mm2reg        register write enable (killed on fault), load flag
//   dreq, dwe, daddr     memory request, write select, word address
//   dwdata, dbe          lane-replicated store data, byte enables
//   mstall               freeze PC, IF/ID, ID/EX and this register
//   mmisalign, mbuserr   single-cycle fault pulses
// ---------------------------------------------------------------------------
module pipemem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [1:0]  esize,
    input  logic        esext,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic [31:0] malu,
    output logic [31:0] mmo,
    output logic [4:0]  mrn,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic [3:0]  dbe,
    output logic        mstall,
    output logic        mmisalign,
    output logic        mbuserr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic [31:0]     mb;
    logic            mwreg_q;
    logic            mwmem;
    logic [1:0]      msize;
    logic            msext;

    logic            memop;
    logic            is_byte;
    logic            is_half;
    logic            is_word;
    logic            misalign;
    logic [31:0]     lane_shift;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    // EX/MEM register; reset value is a bubble.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            malu    <= '0;
            mb      <= '0;
            mrn     <= '0;
            mwreg_q <= 1'b0;
            mm2reg  <= 1'b0;
            mwmem   <= 1'b0;
            msize   <= '0;
            msext   <= 1'b0;
        end else if (!mstall) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            malu    <= ealu;
            mb      <= eb;
            mrn     <= ern;
            mwreg_q <= ewreg;
            mm2reg  <= em2reg;
            mwmem   <= ewmem;
            msize   <= esize;
            msext   <= esext;
        end
    end

    // Reserved size 11 behaves as a word access.
    assign is_byte  = (msize == 2'b00);
    assign is_half  = (msize == 2'b01);
    assign is_word  = msize[1];
    assign memop    = mm2reg | mwmem;
    assign misalign = memop & ((is_half & malu[0]) | (is_word & (malu[1:0] != 2'b00)));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // cnt counts cycles already spent waiting; the IDLE issue cycle is cycle 1,
    // so the abort lands after exactly TIMEOUT stalled cycles.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_nx = state;
        cnt_nx   = cnt;
        dreq     = 1'b0;
        mstall   = 1'b0;
        mbuserr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (memop && !misalign) begin
                    dreq = 1'b1;
                    if (!dack) begin
                        mstall   = 1'b1;
                        state_nx = S_WAIT;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (dack) begin
                    dreq     = 1'b1;
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(TIMEOUT)) begin
                    mbuserr  = 1'b1;
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    dreq   = 1'b1;
                    mstall = 1'b1;
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address, enables and data come straight from the held register, so they
    // stay stable for the whole WAIT period.
    assign dwe       = dreq & mwmem;
    assign daddr     = {malu[31:2], 2'b00};
    assign mmisalign = misalign;
    assign mwreg     = mwreg_q & ~misalign & ~mbuserr;

    always_comb begin
        dbe    = 4'b1111;
        dwdata = mb;
        if (is_byte) begin
            dbe    = 4'b0001 << malu[1:0];
            dwdata = {4{mb[7:0]}};
        end else if (is_half) begin
            dbe    = malu[1] ? 4'b1100 : 4'b0011;
            dwdata = {2{mb[15:0]}};
        end
    end

    assign lane_shift = drdata >> {malu[1:0], 3'b000};
    assign lane_b     = lane_shift[7:0];
    assign lane_h     = malu[1] ? drdata[31:16] : drdata[15:0];

    always_comb begin
        mmo = '0;
        if (mm2reg) begin
            if (is_byte)
                mmo = {{24{msext & lane_b[7]}}, lane_b};
            else if (is_half)
                mmo = {{16{msext & lane_h[15]}}, lane_h};
            else
                mmo = drdata;
        end
    end

endmodule
